f_fetch_queue: RTL and testbench



---
 rtl/f_fetch_queue_pkg.sv | 10 +
 rtl/f_fetch_queue.sv | 71 +++++++
 tb/tb_f_fetch_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/f_fetch_queue_pkg.sv
// f_fetch_queue_pkg: shared fetch constants and the queue entry layout
package f_fetch_queue_pkg;
  localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int FQ_DEPTH = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/f_fetch_queue.sv
// f_fetch_queue: in-order (pc, instr) FIFO between fetch and decode with redirect flush
module f_fetch_queue
  import f_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter logic [31:0] NOP_WORD = f_fetch_queue_pkg::NOP_WORD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  F_pc_in,
  input  logic [31:0]                  F_instr_in,
  input  logic                         F_push,
  output logic                         F_ready,
  output logic                         D_valid,
  output logic [31:0]                  D_pc,
  output logic [31:0]                  D_instr,
  input  logic                         D_pop,
  input  logic                         flush,
  input  logic                         flush_keep_head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fq_entry_t       mem_q [DEPTH];
  fq_entry_t       mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_post;
  logic [CW-1:0]   count_q, count_d, cnt_post;
  logic            push_eff, pop_eff, keep;
  assign F_ready = count_q != CW'(DEPTH);
  assign D_valid = count_q != '0;
  assign D_pc    = D_valid ? mem_q[rd_ptr_q].pc : 32'h0;
  assign D_instr = D_valid ? mem_q[rd_ptr_q].instr : NOP_WORD;
  assign count   = count_q;
  // next state: pop first, then flush (optionally keeping the surviving head) or push
  always_comb begin
    push_eff = F_push & F_ready;
    pop_eff  = D_pop & D_valid;
    rd_post  = rd_ptr_q + AW'(pop_eff);
    cnt_post = count_q - CW'(pop_eff);
    keep     = flush_keep_head & (cnt_post != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_post;
    wr_ptr_d = wr_ptr_q;
    count_d  = cnt_post;
    if (flush) begin
      wr_ptr_d = rd_post + AW'(keep);
      count_d  = keep ? CW'(1) : '0;
    end else if (push_eff) begin
      mem_d[wr_ptr_q] = '{pc: F_pc_in, instr: F_instr_in};
      wr_ptr_d        = wr_ptr_q + AW'(1);
      count_d         = cnt_post + CW'(1);
    end
  end
  // state registers; storage is not reset since count alone defines validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  a_push_full: assert property (@(posedge clk) disable iff (reset) !(F_push && !F_ready))
    else $warning("f_fetch_queue: push while full ignored");
  a_pop_empty: assert property (@(posedge clk) disable iff (reset) !(D_pop && !D_valid))
    else $warning("f_fetch_queue: pop while empty ignored");
endmodule

// File: tb/tb_f_fetch_queue.sv
// tb_f_fetch_queue: scoreboard bench for the fetch queue
module tb_f_fetch_queue;
  import f_fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] BASE = INITIAL_ADDRESS;
  logic clk = 0, reset = 1;
  logic [31:0] F_pc_in = 0, F_instr_in = 0;
  logic F_push = 0, D_pop = 0, flush = 0, flush_keep_head = 0;
  logic F_ready, D_valid;
  logic [31:0] D_pc, D_instr;
  logic [CW-1:0] count;
  fq_entry_t sb[$];
  int checks = 0, errors = 0;

  f_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .F_pc_in(F_pc_in), .F_instr_in(F_instr_in),
    .F_push(F_push), .F_ready(F_ready), .D_valid(D_valid), .D_pc(D_pc),
    .D_instr(D_instr), .D_pop(D_pop), .flush(flush),
    .flush_keep_head(flush_keep_head), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic drive(input bit p, input logic [31:0] pc, input bit pp, input bit fl, input bit k);
    bit pe, po;
    F_push = p; F_pc_in = pc; F_instr_in = ins(pc);
    D_pop = pp; flush = fl; flush_keep_head = k;
    pe = p && sb.size() < DEPTH;
    po = pp && sb.size() > 0;
    if (po) void'(sb.pop_front());
    if (fl) begin
      if (k && sb.size() > 0) while (sb.size() > 1) void'(sb.pop_back());
      else sb.delete();
    end else if (pe) sb.push_back('{pc: pc, instr: ins(pc)});
    @(posedge clk); #1;
    F_push = 0; D_pop = 0; flush = 0; flush_keep_head = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (F_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", F_ready); end
    checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", D_valid); end
    checks++; if (D_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", D_pc); end
    checks++; if (D_instr !== NOP_WORD) begin errors++; $display("FAIL reset_instr got %h exp %h", D_instr, NOP_WORD); end
  endtask

  task automatic test_fill_drain();
    fq_entry_t e;
    for (int i = 0; i < 4; i++) drive(1, BASE + 32'(4*i), 0, 0, 0);
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (F_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", F_ready); end
    for (int i = 0; i < 4; i++) begin
      e = sb[0];
      checks++; if (D_valid !== 1'b1 || D_pc !== e.pc || D_instr !== e.instr || D_pc !== BASE + 32'(4*i))
        begin errors++; $display("FAIL drain_head[%0d] got v=%b %h/%h exp %h/%h", i, D_valid, D_pc, D_instr, e.pc, e.instr); end
      drive(0, 0, 1, 0, 0);
    end
    checks++; if (D_valid !== 1'b0 || D_instr !== 32'h0 || count !== '0)
      begin errors++; $display("FAIL drain_empty got v=%b instr=%h cnt=%0d exp 0/0/0", D_valid, D_instr, count); end
  endtask

  task automatic test_full_push_pop();
    fq_entry_t e;
    for (int i = 0; i < 4; i++) drive(1, BASE + 32'(4*i), 0, 0, 0);
    drive(1, 32'h0000_3099, 1, 0, 0);
    checks++; if (count !== CW'(3) || D_pc !== 32'h0000_3004)
      begin errors++; $display("FAIL full_pushpop got cnt=%0d pc=%h exp 3/00003004", count, D_pc); end
    drive(1, BASE + 32'h10, 0, 0, 0);
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL full_refill got %0d exp 4", count); end
    for (int i = 0; i < 4; i++) begin
      e = sb[0];
      checks++; if (D_pc !== e.pc || D_instr !== e.instr)
        begin errors++; $display("FAIL full_drain[%0d] got %h/%h exp %h/%h", i, D_pc, D_instr, e.pc, e.instr); end
      drive(0, 0, 1, 0, 0);
    end
    checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", D_valid); end
  endtask

  task automatic test_wrap();
    fq_entry_t e;
    drive(1, 32'h0000_5000, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      e = sb[0];
      checks++; if (count !== CW'(1) || D_pc !== 32'h0000_5000 + 32'(4*i) || D_pc !== e.pc || D_instr !== e.instr)
        begin errors++; $display("FAIL wrap[%0d] got cnt=%0d %h/%h exp 1 %h/%h", i, count, D_pc, D_instr, e.pc, e.instr); end
      drive(1, 32'h0000_5004 + 32'(4*i), 1, 0, 0);
    end
    drive(0, 0, 1, 0, 0);
    checks++; if (count !== '0) begin errors++; $display("FAIL wrap_end got %0d exp 0", count); end
  endtask

  task automatic test_flush_discard();
    for (int i = 0; i < 3; i++) drive(1, BASE + 32'(4*i), 0, 0, 0);
    drive(1, BASE + 32'hC, 0, 1, 0);
    checks++; if (count !== '0 || D_valid !== 1'b0)
      begin errors++; $display("FAIL flush_discard got cnt=%0d v=%b exp 0/0", count, D_valid); end
    drive(1, 32'h0000_6000, 0, 0, 0);
    checks++; if (count !== CW'(1) || D_pc !== 32'h0000_6000 || D_instr !== ins(32'h0000_6000))
      begin errors++; $display("FAIL flush_repush got cnt=%0d pc=%h exp 1/00006000", count, D_pc); end
    drive(0, 0, 1, 0, 0);
  endtask

  task automatic test_keep_head();
    fq_entry_t e;
    for (int i = 0; i < 3; i++) drive(1, BASE + 32'(4*i), 0, 0, 0);
    drive(0, 0, 1, 1, 1);
    checks++; if (count !== CW'(1) || D_pc !== 32'h0000_3004)
      begin errors++; $display("FAIL keep_head got cnt=%0d pc=%h exp 1/00003004", count, D_pc); end
    drive(1, 32'h0000_4000, 0, 0, 0);
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL keep_push got %0d exp 2", count); end
    for (int i = 0; i < 2; i++) begin
      e = sb[0];
      checks++; if (D_pc !== e.pc || D_instr !== e.instr)
        begin errors++; $display("FAIL keep_order[%0d] got %h/%h exp %h/%h", i, D_pc, D_instr, e.pc, e.instr); end
      drive(0, 0, 1, 0, 0);
    end
    drive(1, 32'h0000_7000, 0, 0, 0);
    drive(0, 0, 1, 1, 1);
    checks++; if (count !== '0 || D_valid !== 1'b0)
      begin errors++; $display("FAIL keep_none got cnt=%0d v=%b exp 0/0", count, D_valid); end
    drive(0, 0, 0, 0, 1);
    checks++; if (count !== '0) begin errors++; $display("FAIL keep_noflush got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid();
    drive(1, BASE, 0, 0, 0);
    drive(1, BASE + 32'h4, 0, 0, 0);
    reset = 1; F_push = 1; F_pc_in = 32'h0000_8000; D_pop = 1; flush = 1;
    @(posedge clk); #1;
    reset = 0; F_push = 0; D_pop = 0; flush = 0;
    sb.delete();
    checks++; if (count !== '0 || F_ready !== 1'b1 || D_valid !== 1'b0 || D_instr !== 32'h0)
      begin errors++; $display("FAIL reset_mid got cnt=%0d rdy=%b v=%b instr=%h exp 0/1/0/0", count, F_ready, D_valid, D_instr); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_wrap();
    test_flush_discard();
    test_keep_head();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
